// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported memory between instruction fetch and data access,
// sequencing each access through IDLE -> ACCESS (wait states) -> DONE.
module mem_port_arbiter #(
    parameter int ADDR_W          = 8,
    parameter int DATA_W          = 16,
    parameter int WAIT_CYCLES     = 1,
    parameter int MAX_DATA_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          streak_q, streak_d;
    logic                owner_q, owner_d;   // 1 = data port owns the access
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                grant_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            streak_q  <= '0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            streak_q  <= streak_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        f_rdata_d  = f_rdata_q;
        d_rdata_d  = d_rdata_q;
        // Data wins a tie unless fetch has already been passed over MAX_DATA_STREAK times.
        grant_data = d_req && !(f_req && (streak_q == STREAK_MAX));
        case (state_q)
            IDLE: begin
                if (!halt && (f_req || d_req)) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_INIT;
                    owner_d = grant_data;
                    we_d    = grant_data && d_we;
                    addr_d  = grant_data ? d_addr : f_addr;
                    wdata_d = grant_data ? d_wdata : '0;
                    if (grant_data && f_req)
                        streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
                    else
                        streak_d = '0;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q) d_rdata_d = mem_rdata;
                        else         f_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = (state_q == ACCESS);
        mem_we    = (state_q == ACCESS) && we_q;
        mem_addr  = (state_q == ACCESS) ? addr_q : '0;
        mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
        f_done    = (state_q == DONE) && !owner_q;
        d_done    = (state_q == DONE) && owner_q;
        busy      = (state_q != IDLE);
        f_rdata   = f_rdata_q;
        d_rdata   = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction table on a WAIT_CYCLES=1 instance
// plus hand sequences for starvation, halt, reset abort and zero-wait back-to-back fetches.
module tb_mem_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          halt = 1'b0, f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] f_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          f_done, d_done, mem_en, mem_we, busy;
    logic [DW-1:0] f_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic          z_f_req = 1'b0;
    logic [AW-1:0] z_f_addr = '0;
    logic          z_f_done, z_d_done, z_mem_en, z_mem_we, z_busy;
    logic [DW-1:0] z_f_rdata, z_d_rdata, z_mem_wdata, z_mem_rdata;
    logic [AW-1:0] z_mem_addr;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1), .MAX_DATA_STREAK(3)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0), .MAX_DATA_STREAK(3)) dut0 (
        .clk(clk), .rst(rst), .halt(1'b0),
        .f_req(z_f_req), .f_addr(z_f_addr), .f_done(z_f_done), .f_rdata(z_f_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(8'h00), .d_wdata(16'h0000),
        .d_done(z_d_done), .d_rdata(z_d_rdata),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_rdata(z_mem_rdata), .busy(z_busy)
    );

    logic [DW-1:0] mem_model [0:255];
    assign mem_rdata   = mem_model[mem_addr];
    assign z_mem_rdata = {8'hA5, z_mem_addr};
    always @(posedge clk) if (mem_en && mem_we) mem_model[mem_addr] <= mem_wdata;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          f_req, d_req, d_we;
        logic [AW-1:0] f_addr, d_addr;
        logic [DW-1:0] d_wdata;
        logic          exp_d;
        logic [DW-1:0] exp_f_rdata, exp_d_rdata;
    } vec_t;
    vec_t vecs [8];

    // One arbitrated transaction with WAIT_CYCLES=1: ACCESS k=1..2, DONE k=3, IDLE k=4.
    task automatic run_vec(input vec_t v, input int idx);
        int en_cnt = 0, fd_cnt = 0, dd_cnt = 0, done_k = 0;
        logic bus_ok = 1'b1;
        logic [AW-1:0] ea = v.exp_d ? v.d_addr : v.f_addr;
        logic [DW-1:0] ew = (v.exp_d && v.d_we) ? v.d_wdata : 16'h0000;
        f_req = v.f_req; d_req = v.d_req; d_we = v.d_we;
        f_addr = v.f_addr; d_addr = v.d_addr; d_wdata = v.d_wdata;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (mem_en) begin
                en_cnt++;
                if (mem_we !== (v.exp_d & v.d_we) || mem_addr !== ea || (mem_we && mem_wdata !== ew))
                    bus_ok = 1'b0;
            end
            if (f_done) fd_cnt++;
            if (d_done) dd_cnt++;
            if (f_done || d_done) begin
                done_k = k;
                f_req = 1'b0; d_req = 1'b0;
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        $display("vec %0d: f_req=%b d_req=%b we=%b owner_d=%b f_rdata=%h d_rdata=%h",
                 idx, v.f_req, v.d_req, v.d_we, v.exp_d, f_rdata, d_rdata);
        check($sformatf("v%0d mem_en_cycles", idx), 64'(en_cnt), 64'd2);
        check($sformatf("v%0d mem_bus", idx), 64'(bus_ok), 64'd1);
        check($sformatf("v%0d done_cycle", idx), 64'(done_k), 64'd3);
        check($sformatf("v%0d f_done_count", idx), 64'(fd_cnt), 64'(!v.exp_d));
        check($sformatf("v%0d d_done_count", idx), 64'(dd_cnt), 64'(v.exp_d));
        check($sformatf("v%0d f_rdata", idx), 64'(f_rdata), 64'(v.exp_f_rdata));
        check($sformatf("v%0d d_rdata", idx), 64'(d_rdata), 64'(v.exp_d_rdata));
        check($sformatf("v%0d busy_idle", idx), 64'(busy), 64'd0);
    endtask

    logic exp_owner [8];
    logic [3:0] exp_streak [8];

    initial begin
        int got, cyc, last_cyc, seen;
        for (int i = 0; i < 256; i++) mem_model[i] = 16'hC000 | 16'(i);
        mem_model[8'h10] = 16'hBEEF;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 16'h0000, 1'b0, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h20, 16'h1234, 1'b1, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 16'h0000, 1'b0, 16'h1234, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h10, 16'h0000, 1'b1, 16'h1234, 16'hBEEF};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h10, 16'h5555, 1'b1, 16'h1234, 16'hBEEF};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 16'h0000, 1'b0, 16'h5555, 16'hBEEF};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 8'h40, 8'h20, 16'h0000, 1'b1, 16'h5555, 16'h1234};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 16'h0000, 1'b0, 16'hC0FF, 16'h1234};

        exp_owner  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_streak = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

        // Reset state
        tick(); tick();
        check("reset outputs",
              {mem_en, mem_we, f_done, d_done, busy, mem_addr, mem_wdata, f_rdata, d_rdata}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Starvation bound with both requests held
        f_req = 1'b1; f_addr = 8'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
        got = 0;
        for (int c = 0; c < 100 && got < 8; c++) begin
            tick();
            if (f_done || d_done) begin
                $display("starve grant %0d: owner_d=%b streak=%0d", got, d_done, dut.streak_q);
                check($sformatf("starve owner %0d", got), 64'(d_done), 64'(exp_owner[got]));
                check($sformatf("starve streak %0d", got), 64'(dut.streak_q), 64'(exp_streak[got]));
                got++;
                if (got == 8) begin f_req = 1'b0; d_req = 1'b0; end
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        check("starve grant count", 64'(got), 64'd8);
        tick();

        // Halt raised during a data read access
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin tick(); if (mem_en) seen = 1; end
        check("halt access started", 64'(seen), 64'd1);
        halt = 1'b1; f_req = 1'b1; f_addr = 8'h20;
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin tick(); if (d_done) seen = 1; end
        d_req = 1'b0;
        $display("halt: data read done=%0d d_rdata=%h", seen, d_rdata);
        check("halt read completes", 64'(seen), 64'd1);
        check("halt d_rdata", 64'(d_rdata), 64'h5555);
        seen = 0;
        for (int c = 0; c < 6; c++) begin tick(); if (mem_en || busy) seen++; end
        check("halt blocks grant", 64'(seen), 64'd0);
        halt = 1'b0;
        tick();
        check("halt release grant", {mem_en, mem_addr}, {1'b1, 8'h20});
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin tick(); if (f_done) seen = 1; end
        f_req = 1'b0;
        check("halt fetch done", 64'(seen), 64'd1);
        check("halt f_rdata", 64'(f_rdata), 64'h1234);
        tick();

        // Reset in the second ACCESS cycle
        f_req = 1'b1; f_addr = 8'h30;
        tick();
        check("rst first access", 64'(mem_en), 64'd1);
        tick();
        #2 rst = 1'b1;
        #1;
        $display("reset mid-access: mem_en=%b busy=%b f_rdata=%h", mem_en, busy, f_rdata);
        check("rst async outputs",
              {mem_en, mem_we, f_done, d_done, busy, mem_addr, mem_wdata, f_rdata, d_rdata}, 64'd0);
        tick();
        check("rst no done", {f_done, d_done, busy}, 64'd0);
        rst = 1'b0;
        tick();
        check("rst regrant", {mem_en, mem_addr}, {1'b1, 8'h30});
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin tick(); if (f_done) seen = 1; end
        f_req = 1'b0;
        check("rst fetch done", 64'(seen), 64'd1);
        check("rst f_rdata", 64'(f_rdata), 64'hC030);
        tick();

        // Zero-wait back-to-back fetches
        z_f_req = 1'b1; z_f_addr = 8'h00;
        got = 0; last_cyc = 0; cyc = 0;
        while (cyc < 20 && got < 3) begin
            tick();
            cyc++;
            if (z_f_done) begin
                $display("wait0 fetch %0d: cycle=%0d rdata=%h", got, cyc, z_f_rdata);
                check($sformatf("wait0 rdata %0d", got), 64'(z_f_rdata), 64'({8'hA5, z_f_addr}));
                check($sformatf("wait0 spacing %0d", got), 64'(cyc - last_cyc), (got == 0) ? 64'd2 : 64'd3);
                last_cyc = cyc;
                got++;
                if (got == 3) z_f_req = 1'b0;
                else z_f_addr = z_f_addr + 8'd1;
            end
        end
        z_f_req = 1'b0;
        check("wait0 fetch count", 64'(got), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
